// File: rtl/wind_input_conditioner.sv
// ----------------------------------------------------------------------------
// wind_input_conditioner
//
// Conditions the raw wind-direction slide switches before they reach the
// runway-lights FSM. Steps:
//   1. Two-flop synchronizer (r_s1 -> r_s2). Only r_s2 feeds the logic.
//   2. Debounce: a new code must be seen for DEBOUNCE_CYCLES consecutive
//      samples before it commits.
//   3. Rejection of the illegal code 2'b11. A stable 11 raises `invalid`
//      and leaves the committed code unchanged.
//
// Compile-time option:
//   WIND_DEBOUNCE_EN - when defined, the full debounce FSM (candidate
//                      register and sample counter) is built and
//                      DEBOUNCE_CYCLES is honoured. When undefined, the
//                      counter and candidate are removed. The block then
//                      acts on every s2 change in the first cycle it is
//                      seen, which is the same as DEBOUNCE_CYCLES = 1.
//
// Ports:
//   clk      in   divided system clock; all state updates on rising edge
//   reset    in   synchronous, active-high
//   sw_in    in   [1:0] raw asynchronous switch levels {SW[1], SW[0]}
//   w1       out  committed wind bit 1 (registered)
//   w0       out  committed wind bit 0 (registered)
//   changed  out  one-cycle pulse after {w1,w0} takes a new value
//   invalid  out  level; high while the debounced input is held at 2'b11
// ----------------------------------------------------------------------------
module wind_input_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] sw_in,
   output logic       w1,
   output logic       w0,
   output logic       changed,
   output logic       invalid
);

   typedef enum logic [1:0] {
      ST_STABLE   = 2'd0,
      ST_SETTLING = 2'd1,
      ST_REJECT   = 2'd2
   } state_t;

   localparam logic [1:0] CODE_ILLEGAL = 2'b11;

   logic [1:0] r_s1;
   logic [1:0] r_s2;
   state_t     r_state;
   state_t     w_state_next;
   logic [1:0] r_committed;
   logic [1:0] w_committed_next;
   logic       r_changed;
   logic       w_changed_next;
   logic       r_invalid;
   logic       w_invalid_next;

   // Request to apply the commit rule to w_eval_code on this edge.
   logic       w_eval;
   logic [1:0] w_eval_code;

`ifdef WIND_DEBOUNCE_EN
   localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   // With a single-sample debounce there is no settling period. A new code
   // is judged on the same edge that first sees it.
   localparam bit              SINGLE   = (DEBOUNCE_CYCLES == 1);

   logic [1:0]       r_cand;
   logic [1:0]       w_cand_next;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_next;
`endif

   // ------------------------------------------------------------------------
   // State register (synchronizer plus all FSM state)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1        <= 2'b00;
         r_s2        <= 2'b00;
         r_state     <= ST_STABLE;
         r_committed <= 2'b00;
         r_changed   <= 1'b0;
         r_invalid   <= 1'b0;
`ifdef WIND_DEBOUNCE_EN
         r_cand      <= 2'b00;
         r_cnt       <= '0;
`endif
      end else begin
         r_s1        <= sw_in;
         r_s2        <= r_s1;
         r_state     <= w_state_next;
         r_committed <= w_committed_next;
         r_changed   <= w_changed_next;
         r_invalid   <= w_invalid_next;
`ifdef WIND_DEBOUNCE_EN
         r_cand      <= w_cand_next;
         r_cnt       <= w_cnt_next;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
`ifdef WIND_DEBOUNCE_EN
   always_comb begin
      w_state_next     = r_state;
      w_committed_next = r_committed;
      w_changed_next   = 1'b0;
      w_invalid_next   = r_invalid;
      w_cand_next      = r_cand;
      w_cnt_next       = r_cnt;
      w_eval           = 1'b0;
      w_eval_code      = r_s2;

      case (r_state)
         ST_STABLE: begin
            if (r_s2 != r_committed) begin
               if (SINGLE) begin
                  w_eval = 1'b1;
               end else begin
                  w_cand_next  = r_s2;
                  w_cnt_next   = CNT_ONE;
                  w_state_next = ST_SETTLING;
               end
            end
         end

         ST_SETTLING: begin
            if (r_s2 == r_committed) begin
               // Bounced back to the committed code. Drop the candidate quietly.
               w_state_next = ST_STABLE;
               w_cnt_next   = '0;
            end else if (r_s2 != r_cand) begin
               w_cand_next = r_s2;
               w_cnt_next  = CNT_ONE;
            end else if (r_cnt >= CNT_LAST) begin
               w_eval      = 1'b1;
               w_eval_code = r_cand;
            end else begin
               w_cnt_next = r_cnt + CNT_ONE;
            end
         end

         ST_REJECT: begin
            if (r_s2 != CODE_ILLEGAL) begin
               w_invalid_next = 1'b0;
               if (r_s2 == r_committed) begin
                  w_state_next = ST_STABLE;
               end else if (SINGLE) begin
                  w_eval = 1'b1;
               end else begin
                  w_cand_next  = r_s2;
                  w_cnt_next   = CNT_ONE;
                  w_state_next = ST_SETTLING;
               end
            end
         end

         default: begin
            w_state_next = ST_STABLE;
            w_cnt_next   = '0;
         end
      endcase

      // Commit rule: a legal code is committed. The illegal code parks in REJECT.
      if (w_eval) begin
         w_cand_next = w_eval_code;
         w_cnt_next  = '0;
         if (w_eval_code != CODE_ILLEGAL) begin
            w_committed_next = w_eval_code;
            w_changed_next   = 1'b1;
            w_state_next     = ST_STABLE;
         end else begin
            w_invalid_next = 1'b1;
            w_state_next   = ST_REJECT;
         end
      end
   end
`else
   always_comb begin
      w_state_next     = r_state;
      w_committed_next = r_committed;
      w_changed_next   = 1'b0;
      w_invalid_next   = r_invalid;
      w_eval           = 1'b0;
      w_eval_code      = r_s2;

      case (r_state)
         ST_STABLE: begin
            if (r_s2 != r_committed) begin
               w_eval = 1'b1;
            end
         end

         ST_REJECT: begin
            if (r_s2 != CODE_ILLEGAL) begin
               w_invalid_next = 1'b0;
               if (r_s2 == r_committed) begin
                  w_state_next = ST_STABLE;
               end else begin
                  w_eval = 1'b1;
               end
            end
         end

         // There is no settling period in this build.
         default: begin
            w_state_next = ST_STABLE;
         end
      endcase

      if (w_eval) begin
         if (w_eval_code != CODE_ILLEGAL) begin
            w_committed_next = w_eval_code;
            w_changed_next   = 1'b1;
            w_state_next     = ST_STABLE;
         end else begin
            w_invalid_next = 1'b1;
            w_state_next   = ST_REJECT;
         end
      end
   end
`endif

   // ------------------------------------------------------------------------
   // Output logic: every output comes straight from a register
   // ------------------------------------------------------------------------
   always_comb begin
      w1      = r_committed[1];
      w0      = r_committed[0];
      changed = r_changed;
      invalid = r_invalid;
   end

endmodule

// File: tb/tb_wind_input_conditioner.sv
// ----------------------------------------------------------------------------
// Testbench for wind_input_conditioner.
//
// The reference model treats the conditioner as a run-length detector on
// the synchronized input. The model delays sw_in by two samples. It then
// counts how many consecutive samples the delayed value has held. When a
// value different from the committed one reaches a run of D samples, the
// model commits it, or flags it as invalid if it is 11. The invalid flag
// stays set until the delayed input leaves 11.
// ----------------------------------------------------------------------------
module tb_wind_input_conditioner;

`ifdef WIND_DEBOUNCE_EN
   localparam int D = 4;
`else
   localparam int D = 1;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] sw_in = 2'b00;
   logic       w1;
   logic       w0;
   logic       changed;
   logic       invalid;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model state.
   logic [1:0] m_s1;
   logic [1:0] m_s2;
   logic [1:0] m_prev;
   logic [1:0] m_comm;
   logic       m_chg;
   logic       m_inv;
   int         m_run;

   always #5 clk = ~clk;

   wind_input_conditioner #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .sw_in  (sw_in),
      .w1     (w1),
      .w0     (w0),
      .changed(changed),
      .invalid(invalid)
   );

   function automatic logic [3:0] dut_out();
      return {w1, w0, changed, invalid};
   endfunction

   function automatic logic [3:0] mdl_out();
      return {m_comm, m_chg, m_inv};
   endfunction

   // Drive one clock edge and advance the model. Outputs are then valid 1 time unit later.
   task automatic step(input logic [1:0] sw, input logic rst);
      sw_in = sw;
      reset = rst;
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_s1 = 2'b00; m_s2 = 2'b00; m_prev = 2'b00; m_comm = 2'b00;
         m_chg = 1'b0; m_inv = 1'b0; m_run = 0;
      end else begin
         m_run = (m_s2 == m_prev) ? m_run + 1 : 1;
         m_chg = 1'b0;
         if (m_inv && m_s2 != 2'b11) m_inv = 1'b0;
         if (!m_inv && m_s2 != m_comm && m_run == D) begin
            if (m_s2 == 2'b11) m_inv = 1'b1;
            else begin
               m_comm = m_s2;
               m_chg  = 1'b1;
            end
         end
         m_prev = m_s2;
         m_s2   = m_s1;
         m_s1   = sw;
      end
      #1;
   endtask

   task automatic test_reset();
      step(2'b00, 1'b1);
      step(2'b00, 1'b1);
      for (int i = 0; i < 10; i++) begin
         step(2'b00, 1'b0);
         n_checks++;
         if (dut_out() !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_idle cyc=%0d got=%b expected=%b", cyc, dut_out(), 4'b0000);
         end
      end
   endtask

   task automatic test_glitch();
      for (int i = 0; i < 10; i++) begin
         step((i < 2) ? 2'b10 : 2'b00, 1'b0);
         n_checks++;
         if (dut_out() !== mdl_out()) begin
            n_fail++;
            $display("FAIL glitch cyc=%0d got=%b expected=%b", cyc, dut_out(), mdl_out());
         end
      end
   endtask

   task automatic test_commit();
      logic [3:0] exp;
      for (int i = 0; i < 8; i++) begin
         step(2'b01, 1'b0);
         exp = {((i >= D + 1) ? 2'b01 : 2'b00), (i == D + 1), 1'b0};
         n_checks++;
         if (dut_out() !== exp) begin
            n_fail++;
            $display("FAIL commit_latency edge=k+%0d got=%b expected=%b", i, dut_out(), exp);
         end
         n_checks++;
         if (dut_out() !== mdl_out()) begin
            n_fail++;
            $display("FAIL commit_model cyc=%0d got=%b expected=%b", cyc, dut_out(), mdl_out());
         end
      end
   endtask

   task automatic test_bounce();
      for (int i = 0; i < 14; i++) begin
         step((i < 2) ? 2'b10 : ((i < 6) ? 2'b01 : 2'b10), 1'b0);
         n_checks++;
         if (dut_out() !== mdl_out()) begin
            n_fail++;
            $display("FAIL bounce cyc=%0d got=%b expected=%b", cyc, dut_out(), mdl_out());
         end
      end
      n_checks++;
      if ({w1, w0} !== 2'b10) begin
         n_fail++;
         $display("FAIL bounce_final got=%b expected=%b", {w1, w0}, 2'b10);
      end
   endtask

   task automatic test_reject();
      logic [3:0] exp;
      for (int i = 0; i < 8; i++) begin
         step(2'b11, 1'b0);
         exp = {2'b10, 1'b0, (i >= D + 1)};
         n_checks++;
         if (dut_out() !== exp) begin
            n_fail++;
            $display("FAIL reject_hold edge=k+%0d got=%b expected=%b", i, dut_out(), exp);
         end
      end
      for (int i = 0; i < 8; i++) begin
         step(2'b00, 1'b0);
         exp = {((i >= D + 1) ? 2'b00 : 2'b10), (i == D + 1), (i < 2)};
         n_checks++;
         if (dut_out() !== exp) begin
            n_fail++;
            $display("FAIL reject_release edge=k+%0d got=%b expected=%b", i, dut_out(), exp);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [3:0] exp;
      for (int i = 0; i < 4; i++) step(2'b01, 1'b0);
      step(2'b01, 1'b1);
      n_checks++;
      if (dut_out() !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_mid got=%b expected=%b", dut_out(), 4'b0000);
      end
      for (int i = 0; i < 8; i++) begin
         step(2'b01, 1'b0);
         exp = {((i >= D + 1) ? 2'b01 : 2'b00), (i == D + 1), 1'b0};
         n_checks++;
         if (dut_out() !== exp) begin
            n_fail++;
            $display("FAIL reset_release edge=+%0d got=%b expected=%b", i, dut_out(), exp);
         end
      end
   endtask

   task automatic test_random();
      logic [1:0] code;
      int         hold;
      for (int seg = 0; seg < 80; seg++) begin
         code = 2'($urandom_range(0, 3));
         hold = $urandom_range(1, 7);
         for (int h = 0; h < hold; h++) begin
            step(code, ($urandom_range(0, 59) == 0));
            n_checks++;
            if (dut_out() !== mdl_out()) begin
               n_fail++;
               $display("FAIL random cyc=%0d sw=%b got=%b expected=%b", cyc, code, dut_out(), mdl_out());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_commit();
      test_bounce();
      test_reject();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
